scan_response_tx: RTL and testbench



---
 rtl/scan_link_pkg.sv | 19 +
 rtl/scan_response_tx.sv | 111 +++++++++++
 tb/tb_scan_response_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_link_pkg.sv
// Shared definitions for the scan link (transmitter and receiver).
//   tx_state_e  : transmitter frame state (IDLE, DATA, PAR)
//   PARITY_EVEN : value XORed into the data parity to give even parity
//   cnt_width() : width of a beat counter that must reach WIDTH without wrapping
package scan_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } tx_state_e;

    localparam logic PARITY_EVEN = 1'b0;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/scan_response_tx.sv
// Parallel-in, serial-out transmitter for the scan link. Accepts one WIDTH-bit
// word over a valid/ready handshake and shifts it out LSB-first, one bit per
// accepted beat, optionally followed by an even-parity bit.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : parallel word handshake, in_data is the word
//   so_valid/so_ready   : serial bit handshake, so_data is the bit
//   so_last             : current bit is the final bit of the frame
//   busy                : a frame is in progress
module scan_response_tx
    import scan_link_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PARITY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             so_valid,
    input  logic             so_ready,
    output logic             so_data,
    output logic             so_last,
    output logic             busy
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam bit               HAS_PAR  = (PARITY != 0);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    par_d   = (^in_data) ^ PARITY_EVEN;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (so_ready) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = HAS_PAR ? PAR : IDLE;
                    end
                end
            end
            PAR: begin
                if (so_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; rst gates in_ready so no word is
    // taken while the block is being reset.
    always_comb begin
        in_ready = 1'b0;
        so_valid = 1'b0;
        so_data  = 1'b0;
        so_last  = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE: in_ready = !rst;
            DATA: begin
                so_valid = 1'b1;
                so_data  = shreg_q[0];
                so_last  = !HAS_PAR && (cnt_q == LAST_CNT);
            end
            PAR: begin
                so_valid = 1'b1;
                so_data  = par_q;
                so_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Control state, reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath, unreset: only observed outside IDLE, and always reloaded on entry
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_scan_response_tx.sv
// Directed bench for scan_response_tx. Three instances share clk/rst:
//   A: WIDTH=8 PARITY=1, B: WIDTH=8 PARITY=0, C: WIDTH=2 PARITY=1.
module tb_scan_response_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid_a = 0, so_ready_a = 1;
    logic [7:0] in_data_a = '0;
    logic       in_ready_a, so_valid_a, so_data_a, so_last_a, busy_a;

    logic       in_valid_b = 0, so_ready_b = 1;
    logic [7:0] in_data_b = '0;
    logic       in_ready_b, so_valid_b, so_data_b, so_last_b, busy_b;

    logic       in_valid_c = 0, so_ready_c = 1;
    logic [1:0] in_data_c = '0;
    logic       in_ready_c, so_valid_c, so_data_c, so_last_c, busy_c;

    int n_cmp  = 0;
    int n_fail = 0;

    scan_response_tx #(.WIDTH(8), .PARITY(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .so_valid(so_valid_a), .so_ready(so_ready_a),
        .so_data(so_data_a), .so_last(so_last_a), .busy(busy_a));

    scan_response_tx #(.WIDTH(8), .PARITY(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .so_valid(so_valid_b), .so_ready(so_ready_b),
        .so_data(so_data_b), .so_last(so_last_b), .busy(busy_b));

    scan_response_tx #(.WIDTH(2), .PARITY(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .so_valid(so_valid_c), .so_ready(so_ready_c),
        .so_data(so_data_c), .so_last(so_last_c), .busy(busy_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (so_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_so_valid: got %b want 0", so_valid_a); end
        n_cmp++; if (so_data_a !== 1'b0) begin n_fail++; $display("FAIL reset_so_data: got %b want 0", so_data_a); end
        n_cmp++; if (so_last_a !== 1'b0) begin n_fail++; $display("FAIL reset_so_last: got %b want 0", so_last_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_cmp++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_in_rst: got %b want 0", in_ready_a); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready_a); end
    endtask

    // A5 -> 1,0,1,0,0,1,0,1 then parity 0
    task automatic test_a5();
        logic [8:0] exp = 9'b0_1010_0101;
        so_ready_a = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 8'hA5;
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (so_valid_a !== 1'b1) begin n_fail++; $display("FAIL a5_valid beat %0d: got %b want 1", i, so_valid_a); end
            n_cmp++; if (so_data_a !== exp[i]) begin n_fail++; $display("FAIL a5_data beat %0d: got %b want %b", i, so_data_a, exp[i]); end
            n_cmp++; if (so_last_a !== (i == 8)) begin n_fail++; $display("FAIL a5_last beat %0d: got %b want %b", i, so_last_a, (i == 8)); end
            n_cmp++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL a5_in_ready beat %0d: got %b want 0", i, in_ready_a); end
            tick();
        end
        n_cmp++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL a5_ready_return: got %b want 1", in_ready_a); end
        n_cmp++; if (so_valid_a !== 1'b0) begin n_fail++; $display("FAIL a5_idle_valid: got %b want 0", so_valid_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL a5_idle_busy: got %b want 0", busy_a); end
    endtask

    // 07 with so_ready toggling; stall cycles must hold data and last
    task automatic test_stall();
        logic [8:0] exp = 9'b1_0000_0111;
        int beat = 0;
        in_valid_a = 1'b1;
        in_data_a  = 8'h07;
        tick();
        in_valid_a = 1'b0;
        so_ready_a = 1'b0;
        for (int cyc = 0; cyc < 40 && beat < 9; cyc++) begin
            n_cmp++; if (so_valid_a !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc %0d: got %b want 1", cyc, so_valid_a); end
            n_cmp++; if (so_data_a !== exp[beat]) begin n_fail++; $display("FAIL stall_data cyc %0d beat %0d: got %b want %b", cyc, beat, so_data_a, exp[beat]); end
            n_cmp++; if (so_last_a !== (beat == 8)) begin n_fail++; $display("FAIL stall_last cyc %0d beat %0d: got %b want %b", cyc, beat, so_last_a, (beat == 8)); end
            if (so_ready_a) beat++;
            tick();
            so_ready_a = ~so_ready_a;
        end
        n_cmp++; if (beat != 9) begin n_fail++; $display("FAIL stall_timeout: got %0d beats want 9", beat); end
        so_ready_a = 1'b1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL stall_ready_return: got %b want 1", in_ready_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b want 0", busy_a); end
    endtask

    // PARITY=0: FF then 00 with in_valid held high
    task automatic test_back_to_back();
        so_ready_b = 1'b1;
        in_valid_b = 1'b1;
        in_data_b  = 8'hFF;
        n_cmp++; if (in_ready_b !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", in_ready_b); end
        tick();
        in_data_b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (so_valid_b !== 1'b1) begin n_fail++; $display("FAIL b2b_ff_valid beat %0d: got %b want 1", i, so_valid_b); end
            n_cmp++; if (so_data_b !== 1'b1) begin n_fail++; $display("FAIL b2b_ff_data beat %0d: got %b want 1", i, so_data_b); end
            n_cmp++; if (so_last_b !== (i == 7)) begin n_fail++; $display("FAIL b2b_ff_last beat %0d: got %b want %b", i, so_last_b, (i == 7)); end
            n_cmp++; if (in_ready_b !== 1'b0) begin n_fail++; $display("FAIL b2b_ff_ready beat %0d: got %b want 0", i, in_ready_b); end
            tick();
        end
        n_cmp++; if (in_ready_b !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready: got %b want 1", in_ready_b); end
        n_cmp++; if (so_valid_b !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid: got %b want 0", so_valid_b); end
        tick();
        in_valid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (so_valid_b !== 1'b1) begin n_fail++; $display("FAIL b2b_00_valid beat %0d: got %b want 1", i, so_valid_b); end
            n_cmp++; if (so_data_b !== 1'b0) begin n_fail++; $display("FAIL b2b_00_data beat %0d: got %b want 0", i, so_data_b); end
            n_cmp++; if (so_last_b !== (i == 7)) begin n_fail++; $display("FAIL b2b_00_last beat %0d: got %b want %b", i, so_last_b, (i == 7)); end
            tick();
        end
        n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", busy_b); end
    endtask

    // Reset after 3 beats of 3C, then 81 from bit 0
    task automatic test_reset_mid();
        logic [2:0] pre = 3'b100;
        logic [8:0] exp = 9'b0_1000_0001;
        so_ready_a = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 8'h3C;
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (so_data_a !== pre[i]) begin n_fail++; $display("FAIL rmid_pre_data beat %0d: got %b want %b", i, so_data_a, pre[i]); end
            tick();
        end
        rst = 1'b1;
        tick();
        n_cmp++; if (so_valid_a !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", so_valid_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy_a); end
        n_cmp++; if (so_last_a !== 1'b0) begin n_fail++; $display("FAIL rmid_last: got %b want 0", so_last_a); end
        n_cmp++; if (so_data_a !== 1'b0) begin n_fail++; $display("FAIL rmid_data: got %b want 0", so_data_a); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", in_ready_a); end
        in_valid_a = 1'b1;
        in_data_a  = 8'h81;
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (so_data_a !== exp[i]) begin n_fail++; $display("FAIL rmid_81_data beat %0d: got %b want %b", i, so_data_a, exp[i]); end
            n_cmp++; if (so_last_a !== (i == 8)) begin n_fail++; $display("FAIL rmid_81_last beat %0d: got %b want %b", i, so_last_a, (i == 8)); end
            tick();
        end
    endtask

    // in_valid/in_data churn during C3 frame; pending 01 loads only in IDLE
    task automatic test_ignore_input();
        logic [8:0] exp1 = 9'b0_1100_0011;
        logic [8:0] exp2 = 9'b1_0000_0001;
        so_ready_a = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 8'hC3;
        tick();
        for (int i = 0; i < 9; i++) begin
            in_data_a = 8'(i * 37 + 1);
            n_cmp++; if (so_data_a !== exp1[i]) begin n_fail++; $display("FAIL ign_data beat %0d: got %b want %b", i, so_data_a, exp1[i]); end
            n_cmp++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL ign_ready beat %0d: got %b want 0", i, in_ready_a); end
            tick();
        end
        in_data_a = 8'h01;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL ign_idle_ready: got %b want 1", in_ready_a); end
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (so_data_a !== exp2[i]) begin n_fail++; $display("FAIL ign_01_data beat %0d: got %b want %b", i, so_data_a, exp2[i]); end
            n_cmp++; if (so_last_a !== (i == 8)) begin n_fail++; $display("FAIL ign_01_last beat %0d: got %b want %b", i, so_last_a, (i == 8)); end
            tick();
        end
    endtask

    // WIDTH=2, 2'b11 -> 1,1,0
    task automatic test_min_width();
        logic [2:0] exp = 3'b011;
        so_ready_c = 1'b1;
        in_valid_c = 1'b1;
        in_data_c  = 2'b11;
        tick();
        in_valid_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (so_valid_c !== 1'b1) begin n_fail++; $display("FAIL minw_valid beat %0d: got %b want 1", i, so_valid_c); end
            n_cmp++; if (so_data_c !== exp[i]) begin n_fail++; $display("FAIL minw_data beat %0d: got %b want %b", i, so_data_c, exp[i]); end
            n_cmp++; if (so_last_c !== (i == 2)) begin n_fail++; $display("FAIL minw_last beat %0d: got %b want %b", i, so_last_c, (i == 2)); end
            tick();
        end
        n_cmp++; if (in_ready_c !== 1'b1) begin n_fail++; $display("FAIL minw_ready: got %b want 1", in_ready_c); end
        n_cmp++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL minw_busy: got %b want 0", busy_c); end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_ignore_input();
        test_min_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
